button_press_decoder: RTL and testbench

BUTTON_PRESS_DECODER -- requirements
Module: button_press_decoder

---
 rtl/button_pkg.sv | 14 +
 rtl/button_press_decoder_rise_detect.sv | 26 ++
 rtl/button_press_decoder.sv | 152 +++++++++++++++
 tb/tb_button_press_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button press decoder: FSM state encodings
// and the default number of ticks that make a press "long".
package button_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2,
        ARM   = 2'd3
    } btn_state_e;

    localparam int LONG_TICKS_DEFAULT = 16;

endpackage

// File: rtl/button_press_decoder_rise_detect.sv
// rise_detect: flags a 0->1 transition of a level sampled on clk.
// The history register has a configurable reset value so a signal that
// is already high when reset ends is not mistaken for a fresh edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q;

    // Remember last cycle's level so the edge can be seen this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= din;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/button_press_decoder.sv
// button_press_decoder: turns a debounced button level into press,
// release and long-press strobes plus a saturating press counter.
// Optional feature macro: BTN_LONG_PRESS_EN enables tick counting and the
// LONG state; without it long_pulse/long_active stay 0 and tick_in is unused.
module button_press_decoder
    import button_pkg::*;
#(
    parameter int LONG_TICKS = LONG_TICKS_DEFAULT,
    parameter int COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               btn_in,
    input  logic               count_clr,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_pulse,
    output logic               long_active,
    output logic [COUNT_W-1:0] press_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    btn_state_e         state_q;
    btn_state_e         state_d;
    logic               press_d;
    logic               release_d;
    logic               long_d;
    logic               long_act_d;
    logic [COUNT_W-1:0] count_d;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [7:0] LONG_LAST = 8'(LONG_TICKS - 1);

    logic       tick_rise;
    logic [7:0] hold_q;
    logic [7:0] hold_d;

    // History resets high so a tick level present at reset exit is not a tick.
    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_tick_rise (
        .clk  (clk),
        .rst  (rst),
        .din  (tick_in),
        .rise (tick_rise)
    );
`else
    // Tick input and threshold have no function when long presses are off.
    logic unused_long_cfg;
    assign unused_long_cfg = tick_in ^ (LONG_TICKS > 0);
`endif

    // Next-state and next-output decode; release always beats a tick edge.
    always_comb begin
        state_d    = state_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        long_act_d = long_active;
`ifdef BTN_LONG_PRESS_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_in) begin
                    state_d = SHORT;
                    press_d = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            SHORT: begin
                if (!btn_in) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    long_act_d = 1'b0;
                end
`ifdef BTN_LONG_PRESS_EN
                else if (tick_rise) begin
                    hold_d = hold_q + 8'd1;
                    if (hold_q == LONG_LAST) begin
                        state_d    = LONG;
                        long_d     = 1'b1;
                        long_act_d = 1'b1;
                    end
                end
`endif
            end
`ifdef BTN_LONG_PRESS_EN
            LONG: begin
                if (!btn_in) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    long_act_d = 1'b0;
                end
            end
`endif
            ARM: begin
                if (!btn_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase
    end

    // Press counter: clear wins over a coinciding press, and it never wraps.
    always_comb begin
        count_d = press_count;
        if (count_clr) begin
            count_d = '0;
        end else if (press_d && (press_count != COUNT_MAX)) begin
            count_d = press_count + COUNT_W'(1);
        end
    end

    // State and registered outputs; reset parks in ARM until the button is up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARM;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            long_active   <= 1'b0;
            press_count   <= '0;
        end else begin
            state_q       <= state_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            long_active   <= long_act_d;
            press_count   <= count_d;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    // Ticks counted while the current press is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder (LONG_TICKS=4, COUNT_W=2). Expected strobes
// are queued as stimulus is applied and checked by an independent monitor.
module tb_button_press_decoder;

    localparam int TB_LONG_TICKS = 4;
    localparam int TB_COUNT_W    = 2;

    localparam logic [2:0] EV_PRESS   = 3'b100;
    localparam logic [2:0] EV_RELEASE = 3'b010;
    localparam logic [2:0] EV_LONG    = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] count;
        logic       la;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  tick_in = 1'b0;
    logic                  btn_in = 1'b0;
    logic                  count_clr = 1'b0;
    logic                  press_pulse;
    logic                  release_pulse;
    logic                  long_pulse;
    logic                  long_active;
    logic [TB_COUNT_W-1:0] press_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef BTN_LONG_PRESS_EN
    localparam logic LONG_EN = 1'b1;
`else
    localparam logic LONG_EN = 1'b0;
`endif

    button_press_decoder #(
        .LONG_TICKS (TB_LONG_TICKS),
        .COUNT_W    (TB_COUNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_in       (tick_in),
        .btn_in        (btn_in),
        .count_clr     (count_clr),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .long_active   (long_active),
        .press_count   (press_count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (press_pulse || release_pulse || long_pulse) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL unexpected_strobe actual kind=%b count=%0d la=%0b required no strobe",
                         {press_pulse, release_pulse, long_pulse}, press_count, long_active);
            end else begin
                e = exp_q.pop_front();
                if (({press_pulse, release_pulse, long_pulse} !== e.kind) ||
                    (8'(press_count) !== e.count) || (long_active !== e.la)) begin
                    errors = errors + 1;
                    $display("[TB] FAIL strobe actual kind=%b count=%0d la=%0b required kind=%b count=%0d la=%0b",
                             {press_pulse, release_pulse, long_pulse}, press_count, long_active,
                             e.kind, e.count, e.la);
                end
            end
        end
    end

    // Global watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic tick, input logic clr);
        btn_in    = btn;
        tick_in   = tick;
        count_clr = clr;
    endtask

    task automatic expectEvent(input logic [2:0] kind, input int cnt, input logic la);
        exp_t e;
        e.kind  = kind;
        e.count = 8'(cnt);
        e.la    = la;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        stepCycles(3);
        rst = 1'b0;
        checkOutput("reset_count", int'(press_count), 0);
        checkOutput("reset_strobes", int'({press_pulse, release_pulse, long_pulse}), 0);
        checkOutput("reset_long_active", int'(long_active), 0);
    endtask

    task automatic pulseTick(input int high_cycles);
        tick_in = 1'b1;
        stepCycles(high_cycles);
        tick_in = 1'b0;
        stepCycles(2);
    endtask

    task automatic drainQueue(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 30) begin
            stepCycles(1);
            waited++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL %s_missing_strobes actual=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Short press: three ticks, below the long threshold.
        $display("[TB] short press");
        doReset();
        stepCycles(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectEvent(EV_PRESS, 1, 1'b0);
        stepCycles(1);
        for (int i = 0; i < 3; i++) pulseTick(2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEvent(EV_RELEASE, 1, 1'b0);
        stepCycles(2);
        drainQueue("short");
        checkOutput("short_count", int'(press_count), 1);

        // Long press: six ticks, the second one held high for many cycles.
        $display("[TB] long press");
        doReset();
        stepCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectEvent(EV_PRESS, 1, 1'b0);
        stepCycles(1);
        pulseTick(2);
        pulseTick(10);
        pulseTick(2);
        checkOutput("long_active_before_4th", int'(long_active), 0);
        if (LONG_EN) expectEvent(EV_LONG, 1, 1'b1);
        pulseTick(2);
        checkOutput("long_active_after_4th", int'(long_active), int'(LONG_EN));
        pulseTick(2);
        pulseTick(2);
        checkOutput("long_active_held", int'(long_active), int'(LONG_EN));
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEvent(EV_RELEASE, 1, 1'b0);
        stepCycles(2);
        drainQueue("long");
        checkOutput("long_active_released", int'(long_active), 0);
        checkOutput("long_count", int'(press_count), 1);

        // Reset mid-press with the button held throughout.
        $display("[TB] held through reset");
        doReset();
        stepCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectEvent(EV_PRESS, 1, 1'b0);
        stepCycles(3);
        drainQueue("pre_reset");
        doReset();
        stepCycles(5);
        checkOutput("held_count", int'(press_count), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectEvent(EV_PRESS, 1, 1'b0);
        stepCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEvent(EV_RELEASE, 1, 1'b0);
        stepCycles(2);
        drainQueue("repress");
        checkOutput("repress_count", int'(press_count), 1);

        // Saturation with a 2-bit counter, then clear racing a press.
        $display("[TB] saturation and clear");
        doReset();
        stepCycles(2);
        for (int i = 1; i <= 5; i++) begin
            int want;
            want = (i > 3) ? 3 : i;
            applyStimulus(1'b1, 1'b0, 1'b0);
            expectEvent(EV_PRESS, want, 1'b0);
            stepCycles(2);
            applyStimulus(1'b0, 1'b0, 1'b0);
            expectEvent(EV_RELEASE, want, 1'b0);
            stepCycles(2);
            checkOutput("sat_count", int'(press_count), want);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        expectEvent(EV_PRESS, 0, 1'b0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("clear_count", int'(press_count), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEvent(EV_RELEASE, 0, 1'b0);
        stepCycles(2);
        drainQueue("saturate");

        // Release coinciding with the tick that would make the press long.
        $display("[TB] release beats tick");
        doReset();
        stepCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectEvent(EV_PRESS, 1, 1'b0);
        stepCycles(1);
        for (int i = 0; i < 3; i++) pulseTick(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectEvent(EV_RELEASE, 1, 1'b0);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(3);
        drainQueue("race");
        checkOutput("race_long_active", int'(long_active), 0);
        checkOutput("race_count", int'(press_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
